thermo_to_bin_stream: RTL

//   Streaming decoder from thermometer code back to binary; the inverse of bin_to_thermo.

---
 rtl/thermo_pkg.sv | 18 +
 rtl/thermo_to_bin_stream_if.sv | 26 ++
 rtl/thermo_to_bin_stream_decode_core.sv | 16 +
 rtl/thermo_to_bin_stream.sv | 68 ++++++
 4 files changed

// File: rtl/thermo_pkg.sv
// Shared thermometer-domain constants and types (also used by bin_to_thermo and thermo_maj).
package thermo_pkg;
    localparam int BIN_W    = 4;
    localparam int THERMO_W = (1 << BIN_W) - 1;

    typedef logic [THERMO_W-1:0] thermo_t;
    typedef logic [BIN_W-1:0]    bin_t;

    typedef struct packed {
        bin_t bin;
        logic err;
    } dec_t;

    // Saturation ceiling of an error counter of width w.
    function automatic int err_cnt_max(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/thermo_to_bin_stream_if.sv
// Stream bundle for the thermometer-to-binary decoder: input beat, output beat, error counter.
interface thermo_to_bin_stream_if
    import thermo_pkg::*;
#(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    thermo_t              thermo_in;
    logic                 out_valid;
    logic                 out_ready;
    bin_t                 bin_out;
    logic                 out_err;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport slave (
        input  in_valid, thermo_in, out_ready, err_clr,
        output in_ready, out_valid, bin_out, out_err, err_cnt
    );

    modport master (
        output in_valid, thermo_in, out_ready, err_clr,
        input  in_ready, out_valid, bin_out, out_err, err_cnt
    );
endinterface

// File: rtl/thermo_to_bin_stream_decode_core.sv
// Combinational decode: popcount of the code plus detection of any 0-below-1 bubble.
module thermo_decode_core
    import thermo_pkg::*;
(
    input  thermo_t i_code,
    output dec_t    o_dec
);
    always_comb begin
        o_dec = '0;
        // Popcount keeps the value meaningful even when the code has bubbles.
        for (int k = 0; k < THERMO_W; k++) begin
            o_dec.bin = o_dec.bin + bin_t'(i_code[k]);
        end
        o_dec.err = |(i_code[THERMO_W-1:1] & ~i_code[THERMO_W-2:0]);
    end
endmodule

// File: rtl/thermo_to_bin_stream.sv
// Two-stage valid/ready decoder: S1 holds the raw code, S2 the decoded value and bubble flag.
module thermo_to_bin_stream
    import thermo_pkg::*;
#(
    parameter int ERR_CNT_W = 8
)(
    input  logic                   clk,
    input  logic                   rst,
    thermo_to_bin_stream_if.slave  bus
);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = ERR_CNT_W'(err_cnt_max(ERR_CNT_W));

    logic                 r_s1_vld;
    thermo_t              r_s1_code;
    logic                 r_s2_vld;
    dec_t                 r_s2_dec;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic w_s1_ready;
    logic w_in_ready;
    logic w_in_fire;
    logic w_s1_fire;
    logic w_out_err_fire;
    dec_t w_dec;

    thermo_decode_core u_core (
        .i_code (r_s1_code),
        .o_dec  (w_dec)
    );

    assign w_s1_ready     = !r_s2_vld || bus.out_ready;
    // Held low during reset so no beat is accepted into a pipeline that is being flushed.
    assign w_in_ready     = !rst && (!r_s1_vld || w_s1_ready);
    assign w_in_fire      = bus.in_valid && w_in_ready;
    assign w_s1_fire      = r_s1_vld && w_s1_ready;
    assign w_out_err_fire = r_s2_vld && bus.out_ready && r_s2_dec.err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_code <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_dec  <= '0;
        end else begin
            if (w_in_ready) r_s1_vld <= bus.in_valid;
            if (w_in_fire)  r_s1_code <= bus.thermo_in;
            if (w_s1_ready) r_s2_vld <= r_s1_vld;
            if (w_s1_fire)  r_s2_dec <= w_dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (bus.err_clr) begin
            // A clear that coincides with an errored delivery still counts that delivery.
            r_err_cnt <= w_out_err_fire ? ERR_CNT_W'(1) : '0;
        end else if (w_out_err_fire && r_err_cnt != CNT_MAX) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_vld;
    assign bus.bin_out   = r_s2_dec.bin;
    assign bus.out_err   = r_s2_dec.err;
    assign bus.err_cnt   = r_err_cnt;
endmodule
